day_counter: RTL and testbench
==============================

# day_counter

Day-of-month counter for the calendar chain of the digital clock. It advances on the end-of-day pulse from the time-of-day counter and on the user day button. It generates `end_month` for the month counter, and clamps the day when the month or year changes to a shorter month. It reads the current `month` back from the month counter and the `year` from the year counter, so month length and leap-year rules live here.

## Interface
Parameters:
- `YEAR_BASE`, default 2000: calendar year represented by `year == 0`. Must be a multiple of 4.

Ports:
- `sig_1Hz`, input, 1: system tick; all state updates on the rising edge.
- `reset`, input, 1: reset, asynchronous, active-high.
- `end_day`, input, 1: level high for one `sig_1Hz` cycle at 23:59:59 → 00:00:00.
- `day_b`, input, 1: user day-advance request, already debounced, one cycle high per press.
- `month`, input, 4: current month, 1..12, from the month counter.
- `year`, input, 7: years since `YEAR_BASE`, 0..99.
- `day_o`, output, 5: current day of month, 1..31.
- `end_month`, output, 1: combinational; high when `end_day` is high on the last day of the current month.

## Operation
- Month length (`last_day`):
  - 31 for months 1, 3, 5, 7, 8, 10, 12.
  - 30 for months 4, 6, 9, 11.
  - 29 for month 2 when `year[1:0] == 0`, otherwise 28.
  - Out-of-range `month` (0, 13..15) gives `last_day = 31`.
- Registered state: `day`, 5 bits. Reset value 1. `day_o = day`.
- `end_month = end_day && (day == last_day)`. This is the only output that feeds the month counter.
- Per `sig_1Hz` rising edge, the first matching rule wins:
  1. `reset` high: `day ← 1` (asynchronous; takes effect with no clock edge).
  2. `day > last_day` (clamp): `day ← last_day`. Any `end_day` or `day_b` in the same cycle is ignored.
  3. `end_day || day_b` is high:
     - if `day == last_day`, then `day ← 1`;
     - otherwise `day ← day + 1`.
  4. Otherwise `day` holds.
- `end_day` and `day_b` high in the same cycle give a single increment, not two.
- `day_b` wrapping the last day to 1 does not assert `end_month`; a manual day wrap never advances the month.
- Clamp case: `day` exceeds `last_day` because `month` or `year` changed (e.g. Jan 31 → `mon_b` → Feb). During that cycle, `end_month` stays 0 because `day != last_day`.
- All arithmetic is 5-bit unsigned. `day` never reaches 0 or exceeds 31.

## Timing
- Increment latency: one `sig_1Hz` edge from `end_day` or `day_b` to the new `day_o`.
- `end_month` follows `day`, `month`, `year` and `end_day` combinationally with zero cycles of latency. The month counter samples it on the same edge that wraps `day` to 1, so day and month roll over together.
- Year rollover: the year counter's `end_year` is formed from the day and month values, so Dec 31 → Jan 1 updates all three counters on one edge.
- Clamp latency: one edge after `month` or `year` changes.
- Reset asserted mid-count: `day_o = 1` immediately. Counting resumes on the first edge after `reset` falls.
- Reset released on a clock edge: that edge does not update `day`.

## Structure
- Shared calendar package holds:
  - month-length constants `DAYS_31 = 31`, `DAYS_30 = 30`, `DAYS_FEB = 28`, `DAYS_FEB_LEAP = 29`;
  - month encodings `JAN` through `DEC` = 1..12;
  - the leap-year test as a function.
- One combinational sub-module, `days_in_month`:
  - inputs: `month` (4 bits), `leap` (1 bit);
  - output: `last_day` (5 bits);
  - reused by the date-setting UI block.
- `day_counter` holds only the `day` register, the priority logic and the `end_month` expression.

## Test plan
- Reset, then 30 cycles of `end_day` with `month = 1`: `day_o` goes 1 → 31. On the next `end_day`, `end_month = 1` on the edge and `day_o = 1` afterwards.
- `month = 2`:
  - `year = 24`: `day_o = 29` is the last day; `end_month` pulses there.
  - `year = 23`: `end_month` pulses at `day_o = 28`, and `day_o = 29` never appears.
- `day = 31`, `month = 1`, then `month` changes to 4: next edge gives `day_o = 30` with `end_month = 0`, even though `end_day` was high in that cycle.
- `day = 30`, `month = 6`, with `day_b` and `end_day` both high: `day_o = 1`, `end_month = 1`, single step. With `day_b` alone on day 30: `day_o = 1`, `end_month = 0`.
- `month = 12`, `day = 31`, `end_day` high: `end_month = 1`, and after the edge `day_o = 1`.
- `reset` pulsed between clock edges at `day = 17`: `day_o = 1` immediately, and there is no extra increment on the following edge.

Source files
------------

// File: rtl/day_counter_pkg.sv
// Shared calendar definitions: month lengths, month encodings and the leap-year rule.
package day_counter_pkg;

  localparam logic [4:0] DAYS_31       = 5'd31;
  localparam logic [4:0] DAYS_30       = 5'd30;
  localparam logic [4:0] DAYS_FEB      = 5'd28;
  localparam logic [4:0] DAYS_FEB_LEAP = 5'd29;

  typedef enum logic [3:0] {
    JAN = 4'd1, FEB = 4'd2, MAR = 4'd3, APR = 4'd4,
    MAY = 4'd5, JUN = 4'd6, JUL = 4'd7, AUG = 4'd8,
    SEP = 4'd9, OCT = 4'd10, NOV = 4'd11, DEC = 4'd12
  } month_e;

  // Every fourth year is a leap year; the clock only spans one century from a
  // base that is itself divisible by four, so the century exceptions never apply.
  function automatic logic is_leap(input int unsigned cal_year);
    return (cal_year % 4) == 0;
  endfunction

endpackage

// File: rtl/day_counter_days_in_month.sv
// Combinational month-length lookup, shared with the date-setting UI.
module days_in_month
  import day_counter_pkg::*;
(
  input  logic [3:0] month,
  input  logic       leap,
  output logic [4:0] last_day
);

  always_comb begin
    last_day = DAYS_31;
    case (month)
      JAN, MAR, MAY, JUL, AUG, OCT, DEC: last_day = DAYS_31;
      APR, JUN, SEP, NOV:                last_day = DAYS_30;
      FEB:                               last_day = leap ? DAYS_FEB_LEAP : DAYS_FEB;
      // Illegal month codes fall back to the longest month so no day is lost.
      default:                           last_day = DAYS_31;
    endcase
  end

endmodule

// File: rtl/day_counter.sv
// Day-of-month counter: advances on end-of-day or the day button, clamps on
// shorter months and tells the month counter when the month rolls over.
module day_counter
  import day_counter_pkg::*;
#(
  parameter int unsigned YEAR_BASE = 2000
) (
  input  logic       sig_1Hz,
  input  logic       reset,
  input  logic       end_day,
  input  logic       day_b,
  input  logic [3:0] month,
  input  logic [6:0] year,
  output logic [4:0] day_o,
  output logic       end_month
);

  logic [4:0] day_q;
  logic [4:0] day_d;
  logic [4:0] last_day;
  logic       leap;

  assign leap = is_leap(YEAR_BASE + 32'(year));

  days_in_month u_days_in_month (
    .month    (month),
    .leap     (leap),
    .last_day (last_day)
  );

  // Clamping wins over counting so a shortened month never skips past its end.
  always_comb begin
    day_d = day_q;
    if (day_q > last_day) begin
      day_d = last_day;
    end else if (end_day || day_b) begin
      day_d = (day_q == last_day) ? 5'd1 : day_q + 5'd1;
    end
  end

  always_ff @(posedge sig_1Hz or posedge reset) begin
    if (reset) begin
      day_q <= 5'd1;
    end else begin
      day_q <= day_d;
    end
  end

  // Only the end-of-day tick rolls the month; a manual day wrap does not.
  assign end_month = end_day && (day_q == last_day);
  assign day_o     = day_q;

endmodule

// File: tb/tb_day_counter.sv
// Self-checking bench for day_counter: vector table, directed corner sequences
// and randomized traffic against a calendar reference model.
module tb_day_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       ed;
  logic       db;
  logic [3:0] mon;
  logic [6:0] yr;
  logic [4:0] day_o;
  logic       end_month;

  int checks = 0;
  int errors = 0;
  int mdl_day;

  day_counter #(.YEAR_BASE(2000)) dut (
    .sig_1Hz   (clk),
    .reset     (rst),
    .end_day   (ed),
    .day_b     (db),
    .month     (mon),
    .year      (yr),
    .day_o     (day_o),
    .end_month (end_month)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ed;
    logic       db;
    logic [3:0] mon;
    logic [6:0] yr;
    int         exp_em;
    int         exp_day;
  } vec_t;

  vec_t vecs[8];

  // Calendar reference: month lengths from a table, leap years from the full year.
  function automatic int ref_last(input int m, input int y);
    int len[13] = '{31, 31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m < 1 || m > 12) return 31;
    if (m == 2 && ((2000 + y) % 4 == 0)) return 29;
    return len[m];
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive at the falling edge, check end_month mid-cycle, day after the edge.
  task automatic apply(input logic e, input logic b, input logic [3:0] m,
                       input logic [6:0] y, output int em_seen, output int day_seen);
    int last;
    int exp_em;
    @(negedge clk);
    ed = e; db = b; mon = m; yr = y;
    #1;
    last   = ref_last(int'(m), int'(y));
    exp_em = (e && mdl_day == last) ? 1 : 0;
    em_seen = int'(end_month);
    check("end_month", em_seen, exp_em);
    if (mdl_day > last) mdl_day = last;
    else if (e || b) mdl_day = (mdl_day == last) ? 1 : mdl_day + 1;
    @(posedge clk);
    #1;
    day_seen = int'(day_o);
    check("day_o", day_seen, mdl_day);
  endtask

  task automatic do_reset();
    @(negedge clk);
    ed = 1'b0; db = 1'b0;
    #2 rst = 1'b1;
    #1 check("async_reset", int'(day_o), 1);
    #1 rst = 1'b0;
    mdl_day = 1;
  endtask

  task automatic goto_day(input int d, input logic [3:0] m, input logic [6:0] y);
    int em, dy;
    do_reset();
    for (int i = 1; i < d; i++) apply(1'b0, 1'b1, m, y, em, dy);
  endtask

  initial begin
    int em, dy;
    rst = 1'b1; ed = 1'b0; db = 1'b0; mon = 4'd1; yr = 7'd0;
    mdl_day = 1;
    #1 check("reset_state", int'(day_o), 1);
    check("reset_end_month", int'(end_month), 0);
    #2 rst = 1'b0;

    // Vector table, applied in order from day 1.
    vecs[0] = '{1'b0, 1'b1, 4'd6,  7'd0,  0, 2};
    vecs[1] = '{1'b1, 1'b1, 4'd6,  7'd0,  0, 3};
    vecs[2] = '{1'b0, 1'b0, 4'd6,  7'd0,  0, 3};
    vecs[3] = '{1'b1, 1'b0, 4'd2,  7'd23, 0, 4};
    vecs[4] = '{1'b0, 1'b0, 4'd0,  7'd5,  0, 4};
    vecs[5] = '{1'b1, 1'b0, 4'd15, 7'd99, 0, 5};
    vecs[6] = '{1'b0, 1'b1, 4'd11, 7'd1,  0, 6};
    vecs[7] = '{1'b0, 1'b0, 4'd9,  7'd2,  0, 6};
    for (int i = 0; i < 8; i++) begin
      apply(vecs[i].ed, vecs[i].db, vecs[i].mon, vecs[i].yr, em, dy);
      check("vec_em", em, vecs[i].exp_em);
      check("vec_day", dy, vecs[i].exp_day);
    end

    // January: 30 end_day ticks reach 31, the next one rolls the month.
    do_reset();
    for (int i = 0; i < 30; i++) apply(1'b1, 1'b0, 4'd1, 7'd0, em, dy);
    check("jan_31", dy, 31);
    apply(1'b1, 1'b0, 4'd1, 7'd0, em, dy);
    check("jan_end_month", em, 1);
    check("jan_wrap", dy, 1);

    // Leap February ends on 29.
    do_reset();
    for (int i = 0; i < 28; i++) apply(1'b1, 1'b0, 4'd2, 7'd24, em, dy);
    check("feb24_29", dy, 29);
    apply(1'b1, 1'b0, 4'd2, 7'd24, em, dy);
    check("feb24_em", em, 1);
    check("feb24_wrap", dy, 1);

    // Common February ends on 28.
    do_reset();
    for (int i = 0; i < 27; i++) apply(1'b1, 1'b0, 4'd2, 7'd23, em, dy);
    check("feb23_28", dy, 28);
    apply(1'b1, 1'b0, 4'd2, 7'd23, em, dy);
    check("feb23_em", em, 1);
    check("feb23_wrap", dy, 1);

    // Jan 31 then month becomes April: clamp to 30, end_day ignored.
    goto_day(31, 4'd1, 7'd0);
    apply(1'b1, 1'b0, 4'd4, 7'd0, em, dy);
    check("clamp_em", em, 0);
    check("clamp_day", dy, 30);

    // June 30 with both requests: one step and a month rollover.
    goto_day(30, 4'd6, 7'd0);
    apply(1'b1, 1'b1, 4'd6, 7'd0, em, dy);
    check("both_em", em, 1);
    check("both_day", dy, 1);

    // June 30 with the button only: wrap without rollover.
    goto_day(30, 4'd6, 7'd0);
    apply(1'b0, 1'b1, 4'd6, 7'd0, em, dy);
    check("btn_em", em, 0);
    check("btn_day", dy, 1);

    // December 31 end of year.
    goto_day(31, 4'd12, 7'd0);
    apply(1'b1, 1'b0, 4'd12, 7'd0, em, dy);
    check("dec_em", em, 1);
    check("dec_day", dy, 1);

    // Reset between edges at day 17; no extra step afterwards.
    goto_day(17, 4'd1, 7'd0);
    check("pre_reset_17", int'(day_o), 17);
    do_reset();
    apply(1'b0, 1'b0, 4'd1, 7'd0, em, dy);
    check("post_reset_hold", dy, 1);

    // Randomized traffic; the month/year drift slowly so clamps happen too.
    do_reset();
    begin
      logic [3:0] rm;
      logic [6:0] ry;
      rm = 4'd1; ry = 7'd0;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 19) == 0) rm = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 29) == 0) ry = 7'($urandom_range(0, 99));
        apply(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 4) == 0), rm, ry, em, dy);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
